// File: rtl/cog_ram_loader_if.sv
// Hub read handshake plus cog RAM port B write bus used by the coginit loader.
interface cog_ram_loader_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned HW = 14
);
    logic          hub_req;
    logic [HW-1:0] hub_addr;
    logic          hub_ack;
    logic [31:0]   hub_data;
    logic          bena;
    logic          bw;
    logic [AW-1:0] ba;
    logic [31:0]   bd;

    modport master (
        output hub_req, hub_addr, bena, bw, ba, bd,
        input  hub_ack, hub_data
    );

    modport slave (
        input  hub_req, hub_addr, bena, bw, ba, bd,
        output hub_ack, hub_data
    );
endinterface

// File: rtl/cog_ram_loader.sv
// Coginit load path: copies LONGS longs from hub memory into cog RAM port B,
// starting at cog address 0. All outputs are registered.
module cog_ram_loader #(
    parameter int unsigned LONGS = 496,
    parameter int unsigned AW    = 9,
    parameter int unsigned HW    = 14
) (
    input  logic            clk,
    input  logic            nres,
    input  logic            start,
    input  logic            abort,
    input  logic [HW-1:0]   hub_ptr,
    output logic            busy,
    output logic            done,
    cog_ram_loader_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWrite, StDone} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] base_q, base_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic          busy_d, done_d, hub_req_d, bena_d;
    logic [HW-1:0] hub_addr_d;
    logic [AW-1:0] ba_d;
    logic [31:0]   bd_d;

    logic last;
    assign last = (cnt_q == AW'(LONGS - 1));

    // State register.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus base/count bookkeeping.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    base_d  = hub_ptr;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                // abort wins over a coincident ack; the acked data is dropped
                if (abort) begin
                    state_d = StIdle;
                end else if (bus.hub_ack) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (last) begin
                    state_d = StDone;
                end else begin
                    state_d = StReq;
                    cnt_d   = cnt_q + AW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        busy_d     = (state_d == StReq) || (state_d == StWrite);
        hub_req_d  = (state_d == StReq);
        hub_addr_d = base_d + HW'(cnt_d);
        bena_d     = (state_d == StWrite);
        ba_d       = bena_d ? cnt_d : '0;
        // StWrite is only entered from an acked StReq, so hub_data is valid here
        bd_d       = bena_d ? bus.hub_data : '0;
        done_d     = (state_d == StDone);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            base_q       <= '0;
            cnt_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.hub_req  <= 1'b0;
            bus.hub_addr <= '0;
            bus.bena     <= 1'b0;
            bus.bw       <= 1'b0;
            bus.ba       <= '0;
            bus.bd       <= '0;
        end else begin
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            busy         <= busy_d;
            done         <= done_d;
            bus.hub_req  <= hub_req_d;
            bus.hub_addr <= hub_addr_d;
            bus.bena     <= bena_d;
            bus.bw       <= bena_d;
            bus.ba       <= ba_d;
            bus.bd       <= bd_d;
        end
    end

endmodule

// File: tb/tb_cog_ram_loader.sv
// Directed bench: a 4-long loader for most scenarios, a default 496-long one for the full run.
module tb_cog_ram_loader;

    logic        clk = 1'b0;
    logic        nres = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] hub_ptr = '0;
    logic        sel = 1'b0;
    int          ack_delay = 0;
    int          tests = 0;
    int          fails = 0;

    logic busy4, done4, busy496, done496;

    cog_ram_loader_if #(.AW(9), .HW(14)) if4 ();
    cog_ram_loader_if #(.AW(9), .HW(14)) if496 ();

    cog_ram_loader #(.LONGS(4), .AW(9), .HW(14)) dut4 (
        .clk     (clk),
        .nres    (nres),
        .start   (start && !sel),
        .abort   (abort && !sel),
        .hub_ptr (hub_ptr),
        .busy    (busy4),
        .done    (done4),
        .bus     (if4)
    );

    cog_ram_loader dut496 (
        .clk     (clk),
        .nres    (nres),
        .start   (start && sel),
        .abort   (abort && sel),
        .hub_ptr (hub_ptr),
        .busy    (busy496),
        .done    (done496),
        .bus     (if496)
    );

    always #5 clk = ~clk;

    // Hub model: data = address ^ A5A5A5A5, ack after ack_delay waiting cycles.
    int wait4 = 0;
    int wait496 = 0;
    assign if4.hub_ack    = if4.hub_req && (wait4 >= ack_delay);
    assign if4.hub_data   = {18'h0, if4.hub_addr} ^ 32'hA5A5A5A5;
    assign if496.hub_ack  = if496.hub_req && (wait496 >= ack_delay);
    assign if496.hub_data = {18'h0, if496.hub_addr} ^ 32'hA5A5A5A5;

    always @(posedge clk) begin
        wait4   <= (!if4.hub_req || if4.hub_ack) ? 0 : wait4 + 1;
        wait496 <= (!if496.hub_req || if496.hub_ack) ? 0 : wait496 + 1;
    end

    // Observed DUT selected by sel.
    logic        m_busy, m_done, m_req, m_ack, m_bena, m_bw;
    logic [13:0] m_addr;
    logic [8:0]  m_ba;
    logic [31:0] m_bd;
    assign m_busy = sel ? busy496 : busy4;
    assign m_done = sel ? done496 : done4;
    assign m_req  = sel ? if496.hub_req : if4.hub_req;
    assign m_ack  = sel ? if496.hub_ack : if4.hub_ack;
    assign m_addr = sel ? if496.hub_addr : if4.hub_addr;
    assign m_bena = sel ? if496.bena : if4.bena;
    assign m_bw   = sel ? if496.bw : if4.bw;
    assign m_ba   = sel ? if496.ba : if4.ba;
    assign m_bd   = sel ? if496.bd : if4.bd;

    int ec = 0;
    int t0 = 0;
    always @(posedge clk) ec <= ec + 1;

    logic [8:0]  wr_ba[$];
    logic [31:0] wr_bd[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    logic [13:0] acked[$];
    int busy_cnt, busy_first, busy_last, unstable, spurious, bena_bw_err;
    logic prev_req, prev_ack;
    logic [13:0] prev_addr;

    task automatic clear_log();
        wr_ba.delete(); wr_bd.delete(); wr_cyc.delete(); done_cyc.delete(); acked.delete();
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        unstable = 0; spurious = 0; bena_bw_err = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    endtask

    // Event log sampled mid-cycle; cycle 1 is the cycle after the accepting edge.
    always @(negedge clk) begin
        int cyc;
        cyc = ec - t0 + 1;
        if (m_busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
        end
        if (m_done) done_cyc.push_back(cyc);
        if (m_bena) begin
            wr_ba.push_back(m_ba);
            wr_bd.push_back(m_bd);
            wr_cyc.push_back(cyc);
            if (!prev_ack) spurious++;
        end
        if (m_bena !== m_bw) bena_bw_err++;
        if (m_req && m_ack) acked.push_back(m_addr);
        if (prev_req && !prev_ack && (!m_req || m_addr !== prev_addr)) unstable++;
        prev_req  = m_req;
        prev_ack  = m_ack;
        prev_addr = m_addr;
    end

    task automatic start_load(input logic [13:0] ptr, input logic with_abort);
        @(negedge clk);
        hub_ptr = ptr;
        start   = 1'b1;
        abort   = with_abort;
        @(posedge clk);
        #1;
        start   = 1'b0;
        abort   = 1'b0;
        hub_ptr = 14'h2ABC;
        t0      = ec;
        clear_log();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!m_busy) break;
        end
        if (i == budget) begin
            tests++; fails++;
            $display("FAIL %s timeout: busy still 1 after %0d cycles, required 0", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 nres = 1'b0;
        #3;
        tests++;
        if ({busy4, done4, if4.hub_req, if4.bena, if4.bw} !== 5'b0) begin
            fails++; $display("FAIL reset_ctl: got %b, required 00000",
                              {busy4, done4, if4.hub_req, if4.bena, if4.bw});
        end
        tests++;
        if ({if4.hub_addr, if4.ba, if4.bd} !== 55'h0) begin
            fails++; $display("FAIL reset_bus: addr=%h ba=%h bd=%h, required 0",
                              if4.hub_addr, if4.ba, if4.bd);
        end
        tests++;
        if ({busy496, done496, if496.hub_req, if496.bena} !== 4'b0) begin
            fails++; $display("FAIL reset_496: got %b, required 0000",
                              {busy496, done496, if496.hub_req, if496.bena});
        end
        @(negedge clk); nres = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy4 !== 1'b0) begin
            fails++; $display("FAIL reset_idle: busy=%b, required 0", busy4);
        end
    endtask

    task automatic test_basic();
        logic [13:0] exp_a [4];
        exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        ack_delay = 0;
        start_load(14'h3FFE, 1'b0);
        wait_idle(40, "basic");
        tests++;
        if (wr_ba.size() != 4) begin
            fails++; $display("FAIL basic_nwr: got %0d writes, required 4", wr_ba.size());
        end
        for (int i = 0; i < 4 && i < acked.size(); i++) begin
            tests++;
            if (acked[i] !== exp_a[i]) begin
                fails++; $display("FAIL basic_addr[%0d]: got %h, required %h", i, acked[i], exp_a[i]);
            end
        end
        for (int i = 0; i < 4 && i < wr_ba.size(); i++) begin
            tests++;
            if (wr_ba[i] !== 9'(i) || wr_bd[i] !== ({18'h0, exp_a[i]} ^ 32'hA5A5A5A5)
                || wr_cyc[i] != 2 * (i + 1)) begin
                fails++; $display("FAIL basic_wr[%0d]: ba=%h bd=%h cyc=%0d, required ba=%h bd=%h cyc=%0d",
                                  i, wr_ba[i], wr_bd[i], wr_cyc[i], i,
                                  {18'h0, exp_a[i]} ^ 32'hA5A5A5A5, 2 * (i + 1));
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 9) begin
            fails++; $display("FAIL basic_done: %0d pulses first at %0d, required 1 at 9",
                              done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
        tests++;
        if (busy_cnt != 8 || busy_first != 1 || busy_last != 8) begin
            fails++; $display("FAIL basic_busy: cnt=%0d %0d..%0d, required 8 cycles 1..8",
                              busy_cnt, busy_first, busy_last);
        end
        tests++;
        if (bena_bw_err != 0) begin
            fails++; $display("FAIL basic_bena_bw: %0d mismatched cycles, required 0", bena_bw_err);
        end
    endtask

    task automatic test_ack_wait();
        ack_delay = 3;
        start_load(14'h0200, 1'b0);
        wait_idle(60, "ack_wait");
        ack_delay = 0;
        tests++;
        if (unstable != 0) begin
            fails++; $display("FAIL wait_stable: %0d req/addr changes before ack, required 0", unstable);
        end
        tests++;
        if (spurious != 0) begin
            fails++; $display("FAIL wait_early_bena: %0d writes without ack, required 0", spurious);
        end
        tests++;
        if (wr_ba.size() != 4) begin
            fails++; $display("FAIL wait_nwr: got %0d writes, required 4", wr_ba.size());
        end
        for (int i = 0; i < wr_cyc.size(); i++) begin
            tests++;
            if (wr_cyc[i] != 5 * (i + 1) || wr_ba[i] !== 9'(i)) begin
                fails++; $display("FAIL wait_wr[%0d]: cyc=%0d ba=%h, required cyc=%0d ba=%h",
                                  i, wr_cyc[i], wr_ba[i], 5 * (i + 1), i);
            end
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 21) begin
            fails++; $display("FAIL wait_done: %0d pulses first at %0d, required 1 at 21",
                              done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_start_ignored();
        start_load(14'h0100, 1'b0);
        repeat (3) @(negedge clk);
        hub_ptr = 14'h2000;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(40, "start_ign");
        tests++;
        if (acked.size() != 4) begin
            fails++; $display("FAIL ign_nreq: got %0d acked requests, required 4", acked.size());
        end
        for (int i = 0; i < acked.size(); i++) begin
            tests++;
            if (acked[i] !== 14'h0100 + 14'(i)) begin
                fails++; $display("FAIL ign_addr[%0d]: got %h, required %h", i, acked[i], 14'h0100 + 14'(i));
            end
        end
        tests++;
        if (done_cyc.size() != 1) begin
            fails++; $display("FAIL ign_done: %0d pulses, required 1", done_cyc.size());
        end
        start_load(14'h0300, 1'b0);
        wait_idle(40, "restart");
        tests++;
        if (wr_ba.size() != 4 || acked.size() == 0 || acked[0] !== 14'h0300) begin
            fails++; $display("FAIL restart: %0d writes first addr %h, required 4 writes from 0300",
                              wr_ba.size(), acked.size() > 0 ? acked[0] : 14'h0);
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 9) begin
            fails++; $display("FAIL restart_done: %0d pulses first at %0d, required 1 at 9",
                              done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_abort();
        start_load(14'h0010, 1'b0);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy4, if4.hub_req, if4.bena} !== 3'b000) begin
            fails++; $display("FAIL abort_next: busy/req/bena=%b, required 000",
                              {busy4, if4.hub_req, if4.bena});
        end
        repeat (4) @(negedge clk);
        tests++;
        if (wr_ba.size() != 2 || wr_ba[0] !== 9'h0 || wr_ba[1] !== 9'h1) begin
            fails++; $display("FAIL abort_wr: %0d writes, required 2 at ba 0,1", wr_ba.size());
        end
        tests++;
        if (done_cyc.size() != 0) begin
            fails++; $display("FAIL abort_done: %0d pulses, required 0", done_cyc.size());
        end
        // start accepted even with abort high in IDLE
        start_load(14'h0020, 1'b1);
        wait_idle(40, "abort_reload");
        tests++;
        if (wr_ba.size() != 4 || wr_ba[0] !== 9'h0 || acked[0] !== 14'h0020) begin
            fails++; $display("FAIL abort_reload: %0d writes first ba %h, required 4 from ba 0 addr 0020",
                              wr_ba.size(), wr_ba.size() > 0 ? wr_ba[0] : 9'h0);
        end
        tests++;
        if (done_cyc.size() != 1) begin
            fails++; $display("FAIL abort_reload_done: %0d pulses, required 1", done_cyc.size());
        end
    endtask

    task automatic test_reset_midrun();
        ack_delay = 3;
        start_load(14'h0040, 1'b0);
        repeat (2) @(negedge clk);
        tests++;
        if (if4.hub_req !== 1'b1 || if4.hub_addr !== 14'h0040) begin
            fails++; $display("FAIL midrst_pre: req=%b addr=%h, required 1 0040", if4.hub_req, if4.hub_addr);
        end
        #2 nres = 1'b0;
        #1;
        tests++;
        if ({busy4, done4, if4.hub_req, if4.bena, if4.bw, if4.hub_addr, if4.ba, if4.bd} !== 60'h0) begin
            fails++; $display("FAIL midrst_zero: busy=%b req=%b addr=%h, required all 0",
                              busy4, if4.hub_req, if4.hub_addr);
        end
        @(negedge clk); nres = 1'b1;
        ack_delay = 0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy4 !== 1'b0 || if4.hub_req !== 1'b0) begin
            fails++; $display("FAIL midrst_idle: busy=%b req=%b, required 0 0", busy4, if4.hub_req);
        end
        start_load(14'h0050, 1'b0);
        wait_idle(40, "midrst_reload");
        tests++;
        if (wr_ba.size() != 4 || wr_ba[0] !== 9'h0 || done_cyc.size() != 1) begin
            fails++; $display("FAIL midrst_reload: %0d writes %0d done, required 4 writes 1 done",
                              wr_ba.size(), done_cyc.size());
        end
    endtask

    task automatic test_long_run();
        sel = 1'b1;
        start_load(14'h1234, 1'b0);
        wait_idle(1100, "long");
        tests++;
        if (wr_ba.size() != 496) begin
            fails++; $display("FAIL long_nwr: got %0d writes, required 496", wr_ba.size());
        end
        tests++;
        if (wr_ba.size() == 0 || wr_ba[wr_ba.size() - 1] !== 9'h1EF
            || wr_bd[wr_bd.size() - 1] !== 32'hA5A5B186) begin
            fails++; $display("FAIL long_last: ba=%h bd=%h, required 1ef a5a5b186",
                              wr_ba.size() > 0 ? wr_ba[wr_ba.size() - 1] : 9'h0,
                              wr_bd.size() > 0 ? wr_bd[wr_bd.size() - 1] : 32'h0);
        end
        tests++;
        if (busy_cnt != 992 || busy_first != 1 || busy_last != 992) begin
            fails++; $display("FAIL long_busy: cnt=%0d %0d..%0d, required 992 cycles 1..992",
                              busy_cnt, busy_first, busy_last);
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != 993) begin
            fails++; $display("FAIL long_done: %0d pulses first at %0d, required 1 at 993",
                              done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
        sel = 1'b0;
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic();
        test_ack_wait();
        test_start_ignored();
        test_abort();
        test_reset_midrun();
        test_long_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
